// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard control for the EX-stage operand muxes.
// Tracks EX/MEM destinations and emits registered select codes aligned with EX.
module fwd_hazard_ctrl #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              in_clk,
    input  logic              in_rst,
    input  logic              in_valid_id,
    input  logic [ADDR_W-1:0] in_src1_id,
    input  logic [ADDR_W-1:0] in_src2_id,
    input  logic              in_use1_id,
    input  logic              in_use2_id,
    input  logic [ADDR_W-1:0] in_dst_id,
    input  logic              in_wr_en_id,
    input  logic              in_is_load_id,
    input  logic              in_flush,
    output logic              out_stall,
    output logic [1:0]        out_cntrl_m2,
    output logic [1:0]        out_cntrl_m3,
    output logic [CNT_W-1:0]  out_stall_cnt
);

    localparam int unsigned SEL_W = 2;
    localparam logic [SEL_W-1:0] SEL_RF  = 2'b11;
    localparam logic [SEL_W-1:0] SEL_MEM = 2'b01;
    localparam logic [SEL_W-1:0] SEL_WB  = 2'b00;

    logic              ex_v_q,   ex_v_d;
    logic              ex_wr_q,  ex_wr_d;
    logic              ex_ld_q,  ex_ld_d;
    logic [ADDR_W-1:0] ex_dst_q, ex_dst_d;
    logic              mem_v_q,  mem_v_d;
    logic              mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0] mem_dst_q, mem_dst_d;
    logic [SEL_W-1:0]  m2_q, m2_d;
    logic [SEL_W-1:0]  m3_q, m3_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic ex_writes_c, mem_writes_c;
    logic ex_hit1_c, ex_hit2_c, mem_hit1_c, mem_hit2_c;
    logic stall_c, accept_c;

    // Nearest producer wins: EX result (in MEM next cycle) beats MEM result (in WB).
    function automatic logic [SEL_W-1:0] pick_sel(input logic used, input logic ex_hit,
                                                  input logic mem_hit);
        if (used && ex_hit)       return SEL_MEM;
        else if (used && mem_hit) return SEL_WB;
        else                      return SEL_RF;
    endfunction

    always_comb begin
        ex_writes_c  = ex_v_q  & ex_wr_q  & (ex_dst_q  != '0);
        mem_writes_c = mem_v_q & mem_wr_q & (mem_dst_q != '0);
        ex_hit1_c    = ex_writes_c  & (ex_dst_q  == in_src1_id);
        ex_hit2_c    = ex_writes_c  & (ex_dst_q  == in_src2_id);
        mem_hit1_c   = mem_writes_c & (mem_dst_q == in_src1_id);
        mem_hit2_c   = mem_writes_c & (mem_dst_q == in_src2_id);
        stall_c      = in_valid_id & ~in_flush & ex_ld_q &
                       ((in_use1_id & ex_hit1_c) | (in_use2_id & ex_hit2_c));
        accept_c     = in_valid_id & ~stall_c & ~in_flush;
    end

    // Next-state: MEM always takes EX; EX takes ID or a bubble.
    always_comb begin
        mem_v_d   = ex_v_q;
        mem_wr_d  = ex_wr_q;
        mem_dst_d = ex_dst_q;
        ex_v_d    = 1'b0;
        ex_wr_d   = 1'b0;
        ex_ld_d   = 1'b0;
        ex_dst_d  = '0;
        m2_d      = SEL_RF;
        m3_d      = SEL_RF;
        cnt_d     = cnt_q;
        if (accept_c) begin
            ex_v_d   = 1'b1;
            ex_wr_d  = in_wr_en_id;
            ex_ld_d  = in_is_load_id;
            ex_dst_d = in_dst_id;
            m2_d     = pick_sel(in_use1_id, ex_hit1_c, mem_hit1_c);
            m3_d     = pick_sel(in_use2_id, ex_hit2_c, mem_hit2_c);
        end
        if (stall_c && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            ex_v_q    <= 1'b0;
            ex_wr_q   <= 1'b0;
            ex_ld_q   <= 1'b0;
            ex_dst_q  <= '0;
            mem_v_q   <= 1'b0;
            mem_wr_q  <= 1'b0;
            mem_dst_q <= '0;
            m2_q      <= SEL_RF;
            m3_q      <= SEL_RF;
            cnt_q     <= '0;
        end else begin
            ex_v_q    <= ex_v_d;
            ex_wr_q   <= ex_wr_d;
            ex_ld_q   <= ex_ld_d;
            ex_dst_q  <= ex_dst_d;
            mem_v_q   <= mem_v_d;
            mem_wr_q  <= mem_wr_d;
            mem_dst_q <= mem_dst_d;
            m2_q      <= m2_d;
            m3_q      <= m3_d;
            cnt_q     <= cnt_d;
        end
    end

    assign out_stall     = stall_c;
    assign out_cntrl_m2  = m2_q;
    assign out_cntrl_m3  = m3_q;
    assign out_stall_cnt = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed self-checking bench for fwd_hazard_ctrl; counter width reduced so
// saturation is reachable in a short run.
module tb_fwd_hazard_ctrl;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned SAT_STALLS = (1 << CNT_W) + 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              valid;
    logic [ADDR_W-1:0] src1, src2, dst;
    logic              use1, use2, wr_en, is_load, flush;
    logic              stall;
    logic [1:0]        m2, m3;
    logic [CNT_W-1:0]  cnt;

    int n_assert = 0;
    int n_fail   = 0;

    fwd_hazard_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .in_clk        (clk),
        .in_rst        (rst),
        .in_valid_id   (valid),
        .in_src1_id    (src1),
        .in_src2_id    (src2),
        .in_use1_id    (use1),
        .in_use2_id    (use2),
        .in_dst_id     (dst),
        .in_wr_en_id   (wr_en),
        .in_is_load_id (is_load),
        .in_flush      (flush),
        .out_stall     (stall),
        .out_cntrl_m2  (m2),
        .out_cntrl_m3  (m3),
        .out_stall_cnt (cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic nop();
        valid = 1'b0; src1 = '0; src2 = '0; use1 = 1'b0; use2 = 1'b0;
        dst = '0; wr_en = 1'b0; is_load = 1'b0; flush = 1'b0;
    endtask

    task automatic alu(input logic [ADDR_W-1:0] d, input logic [ADDR_W-1:0] s1,
                       input logic [ADDR_W-1:0] s2);
        valid = 1'b1; src1 = s1; src2 = s2; use1 = 1'b1; use2 = 1'b1;
        dst = d; wr_en = 1'b1; is_load = 1'b0; flush = 1'b0;
    endtask

    task automatic ld(input logic [ADDR_W-1:0] d, input logic [ADDR_W-1:0] s1);
        valid = 1'b1; src1 = s1; src2 = '0; use1 = 1'b1; use2 = 1'b0;
        dst = d; wr_en = 1'b1; is_load = 1'b1; flush = 1'b0;
    endtask

    task automatic drain();
        nop(); tick(); tick();
    endtask

    initial begin
        int nstall;
        int cycles;
        rst = 1'b1;
        nop();
        tick(); tick();
        chk("rst_m2", 32'(m2), 32'h3);
        chk("rst_m3", 32'(m3), 32'h3);
        chk("rst_cnt", 32'(cnt), 32'h0);
        rst = 1'b0;
        ld(4'd2, 4'd2); settle();
        chk("rst_no_stall", 32'(stall), 32'h0);
        drain();

        // 1: back-to-back ALU dependency
        alu(4'd3, 4'd1, 4'd2); settle();
        chk("t1_stall_a", 32'(stall), 32'h0);
        tick();
        chk("t1_first_m2", 32'(m2), 32'h3);
        chk("t1_first_m3", 32'(m3), 32'h3);
        alu(4'd4, 4'd3, 4'd3); settle();
        chk("t1_stall_b", 32'(stall), 32'h0);
        tick();
        chk("t1_m2", 32'(m2), 32'h1);
        chk("t1_m3", 32'(m3), 32'h1);
        drain();

        // 2: one-instruction gap forwards from writeback
        alu(4'd3, 4'd1, 4'd2); tick();
        nop(); tick();
        alu(4'd5, 4'd1, 4'd3); settle();
        chk("t2_stall", 32'(stall), 32'h0);
        tick();
        chk("t2_m2", 32'(m2), 32'h3);
        chk("t2_m3", 32'(m3), 32'h0);
        drain();

        // 3: load-use hazard, one bubble
        ld(4'd2, 4'd0); tick();
        chk("t3_ld_m2", 32'(m2), 32'h3);
        alu(4'd6, 4'd2, 4'd1); settle();
        chk("t3_stall_on", 32'(stall), 32'h1);
        tick();
        chk("t3_bub_m2", 32'(m2), 32'h3);
        chk("t3_bub_m3", 32'(m3), 32'h3);
        chk("t3_cnt", 32'(cnt), 32'h1);
        settle();
        chk("t3_stall_off", 32'(stall), 32'h0);
        tick();
        chk("t3_m2", 32'(m2), 32'h0);
        chk("t3_m3", 32'(m3), 32'h3);
        chk("t3_cnt_hold", 32'(cnt), 32'h1);
        drain();

        // 4: nearest producer priority, r0 and non-writing producers
        alu(4'd7, 4'd1, 4'd1); tick();
        alu(4'd7, 4'd1, 4'd1); tick();
        alu(4'd8, 4'd7, 4'd0); tick();
        chk("t4_near_m2", 32'(m2), 32'h1);
        chk("t4_r0_m3", 32'(m3), 32'h3);
        drain();
        alu(4'd0, 4'd1, 4'd1); tick();
        alu(4'd9, 4'd0, 4'd0); tick();
        chk("t4_dst0_m2", 32'(m2), 32'h3);
        chk("t4_dst0_m3", 32'(m3), 32'h3);
        drain();
        alu(4'd5, 4'd1, 4'd1); wr_en = 1'b0; tick();
        alu(4'd9, 4'd5, 4'd1); tick();
        chk("t4_nowr_m2", 32'(m2), 32'h3);
        drain();
        ld(4'd0, 4'd1); tick();
        alu(4'd9, 4'd0, 4'd0); settle();
        chk("t4_ld_r0_stall", 32'(stall), 32'h0);
        drain();

        // 5: flush beats stall; reset mid-stall
        ld(4'd2, 4'd0); tick();
        alu(4'd6, 4'd2, 4'd1); flush = 1'b1; settle();
        chk("t5_flush_stall", 32'(stall), 32'h0);
        tick();
        chk("t5_flush_m2", 32'(m2), 32'h3);
        chk("t5_flush_m3", 32'(m3), 32'h3);
        chk("t5_flush_cnt", 32'(cnt), 32'h1);
        alu(4'd10, 4'd6, 4'd6); tick();
        chk("t5_killed_m2", 32'(m2), 32'h3);
        chk("t5_killed_m3", 32'(m3), 32'h3);
        drain();
        ld(4'd2, 4'd0); tick();
        alu(4'd6, 4'd2, 4'd2); settle();
        chk("t5_pre_rst_stall", 32'(stall), 32'h1);
        rst = 1'b1; tick();
        chk("t5_rst_m2", 32'(m2), 32'h3);
        chk("t5_rst_m3", 32'(m3), 32'h3);
        chk("t5_rst_cnt", 32'(cnt), 32'h0);
        rst = 1'b0; settle();
        chk("t5_rst_stall", 32'(stall), 32'h0);
        tick();
        chk("t5_post_m2", 32'(m2), 32'h3);
        chk("t5_post_m3", 32'(m3), 32'h3);
        drain();

        // 6: counter saturation under repeated self-dependent loads
        nstall = 0;
        cycles = 0;
        ld(4'd2, 4'd2);
        while (nstall < int'(SAT_STALLS) && cycles < 4 * int'(SAT_STALLS)) begin
            settle();
            if (stall === 1'b1) nstall++;
            tick();
            cycles++;
            if (nstall == 100 && stall === 1'b0) chk("t6_cnt_mid", 32'(cnt), 32'd100);
        end
        chk("t6_stalls_seen", 32'(nstall), 32'(SAT_STALLS));
        chk("t6_cnt_sat", 32'(cnt), 32'hFF);
        nop(); tick();
        chk("t6_cnt_hold", 32'(cnt), 32'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
